// File: rtl/flash_loader_pkg.sv
// flash_loader_pkg: RAMIO encodings, SPI flash command and loader FSM states shared by the loader files.
package flash_loader_pkg;

    typedef enum logic [1:0] {
        WriteNone = 2'b00,
        WriteByte = 2'b01,
        WriteHalf = 2'b10,
        WriteWord = 2'b11
    } ramio_write_type_e;

    localparam logic [2:0] RAMIO_READ_NONE = 3'b000;
    localparam logic [7:0] FLASH_CMD_READ  = 8'h03;

    typedef enum logic [2:0] {
        Wait,
        Command,
        Receive,
        Write,
        WaitBusy,
        Done
    } flash_loader_state_e;

endpackage

// File: rtl/flash_loader_spi_shifter.sv
// spi_shifter: SPI mode-0 engine with sclk = clk/2, MSB-first 32-bit transmit, byte receive and a clock-stall run input.
module spi_shifter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] load_data_i,
    input  logic        run_i,
    input  logic        cmd_i,
    input  logic        miso_i,
    output logic        sclk_o,
    output logic        mosi_o,
    output logic [7:0]  rx_byte_o,
    output logic        done_o
);
    logic        sclk_q, sclk_d;
    logic [31:0] tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        rise, fall;

    assign rise      = run_i && !sclk_q;
    assign fall      = run_i && sclk_q;
    // A transfer unit ends on its last falling edge so a pause always leaves sclk low.
    assign done_o    = fall && (cmd_i ? cnt_q == 5'd31 : cnt_q[2:0] == 3'd7);
    assign sclk_o    = sclk_q;
    assign mosi_o    = tx_q[31];
    assign rx_byte_o = rx_q;

    always_comb begin
        sclk_d = run_i ? !sclk_q : sclk_q;
        tx_d   = load_i ? load_data_i : fall ? {tx_q[30:0], 1'b0} : tx_q;
        cnt_d  = load_i ? 5'd0 : fall ? cnt_q + 5'd1 : cnt_q;
        rx_d   = rise ? {rx_q[6:0], miso_i} : rx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= 1'b0;
            tx_q   <= '0;
            rx_q   <= '0;
            cnt_q  <= '0;
        end else begin
            sclk_q <= sclk_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/flash_loader.sv
// flash_loader: boot-time copy of SPI flash contents into RAM over RAMIO as little-endian words, then sticky done.
module flash_loader
    import flash_loader_pkg::*;
#(
    parameter int unsigned StartupWaitCycles  = 1_000_000,
    parameter int unsigned FlashTransferBytes = 4096,
    parameter logic [23:0] FlashStartAddress  = 24'h000000,
    parameter logic [31:0] RamStartAddress    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        flash_clk,
    input  logic        flash_miso,
    output logic        flash_mosi,
    output logic        flash_cs,
    output logic        ramio_enable,
    output logic [1:0]  ramio_write_type,
    output logic [2:0]  ramio_read_type,
    output logic [31:0] ramio_address,
    output logic [31:0] ramio_data_in,
    input  logic        ramio_busy,
    output logic        done
);
    localparam int unsigned WW = $clog2(StartupWaitCycles + 2);
    localparam int unsigned CW = $clog2(FlashTransferBytes + 1);

    flash_loader_state_e state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   addr_q, addr_d, word_q, word_d;
    logic [1:0]    lane_q, lane_d;
    logic          cs_q, cs_d;
    logic          load, run, byte_done;
    logic [7:0]    rx_byte;

    spi_shifter u_spi (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load),
        .load_data_i ({FLASH_CMD_READ, FlashStartAddress}),
        .run_i       (run),
        .cmd_i       (state_q == Command),
        .miso_i      (flash_miso),
        .sclk_o      (flash_clk),
        .mosi_o      (flash_mosi),
        .rx_byte_o   (rx_byte),
        .done_o      (byte_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= Wait;
            wait_q  <= WW'(StartupWaitCycles);
            count_q <= '0;
            addr_q  <= RamStartAddress;
            word_q  <= '0;
            lane_q  <= '0;
            cs_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
            cs_q    <= cs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        count_d = count_q;
        addr_d  = addr_q;
        word_d  = word_q;
        lane_d  = lane_q;
        cs_d    = cs_q;
        load    = 1'b0;
        case (state_q)
            Wait: begin
                if (wait_q <= WW'(1)) begin
                    load    = 1'b1;
                    cs_d    = 1'b0;
                    state_d = Command;
                end else wait_d = wait_q - WW'(1);
            end
            Command: state_d = byte_done ? Receive : Command;
            Receive: begin
                if (byte_done) begin
                    word_d[{lane_q, 3'b000} +: 8] = rx_byte;
                    lane_d  = lane_q + 2'd1;
                    state_d = lane_q == 2'd3 ? Write : Receive;
                end
            end
            Write: state_d = ramio_busy ? Write : WaitBusy;
            WaitBusy: begin
                if (!ramio_busy) begin
                    addr_d  = addr_q + 32'd4;
                    count_d = count_q + CW'(4);
                    cs_d    = count_d == CW'(FlashTransferBytes);
                    state_d = cs_d ? Done : Receive;
                end
            end
            default: cs_d = 1'b1;
        endcase
    end

    always_comb begin
        run              = state_q == Command || state_q == Receive;
        ramio_enable     = state_q == Write && !ramio_busy;
        ramio_write_type = ramio_enable ? WriteWord : WriteNone;
        ramio_read_type  = RAMIO_READ_NONE;
        ramio_address    = state_q == Done ? '0 : addr_q;
        ramio_data_in    = ramio_enable ? word_q : '0;
        done             = state_q == Done;
        flash_cs         = cs_q;
    end

endmodule

// File: tb/tb_flash_loader.sv
// tb_flash_loader: scoreboard bench with a flash model and a busy-stretching RAMIO responder.
module tb_flash_loader;
    localparam logic [23:0] FADDR   = 24'h5A0C31;
    localparam logic [31:0] RSTART  = 32'hFFFF_FFF8;
    localparam logic [31:0] EXP_CMD = {8'h03, FADDR};

    logic        clk = 1'b0, rst_n = 1'b0, flash_miso = 1'b0;
    logic        flash_clk, flash_mosi, flash_cs, ramio_enable, done, ramio_busy;
    logic [1:0]  ramio_write_type;
    logic [2:0]  ramio_read_type;
    logic [31:0] ramio_address, ramio_data_in;
    logic        busy_ack = 1'b0, busy_hold = 1'b0;
    assign ramio_busy = busy_ack | busy_hold;

    int checks = 0, failures = 0;
    typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
    wr_t exp_q[$];

    logic [7:0] flash_data [16] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                                    8'h99, 8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00};
    int fbits = 0, fbyte = 0, fbit = 0, cmds_seen = 0, stall_bad = 0, mosi_bad = 0;
    logic [31:0] fcmd = '0;
    logic [7:0]  fcur;
    logic        prev_fclk = 1'b0, prev_en = 1'b0;
    wr_t         e;

    flash_loader #(
        .StartupWaitCycles (10),
        .FlashTransferBytes(12),
        .FlashStartAddress (FADDR),
        .RamStartAddress   (RSTART)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flash_clk       (flash_clk),
        .flash_miso      (flash_miso),
        .flash_mosi      (flash_mosi),
        .flash_cs        (flash_cs),
        .ramio_enable    (ramio_enable),
        .ramio_write_type(ramio_write_type),
        .ramio_read_type (ramio_read_type),
        .ramio_address   (ramio_address),
        .ramio_data_in   (ramio_data_in),
        .ramio_busy      (ramio_busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Flash model: samples mosi on sclk rise, drives the next data bit on sclk fall once the 32-bit header is in.
    always @(negedge clk) begin
        if (flash_cs) begin
            fbits = 0; fbyte = 0; fbit = 0; fcmd = '0; flash_miso = 1'b0;
        end else begin
            if (flash_clk && !prev_fclk) begin
                if (fbits < 32) begin
                    fcmd = {fcmd[30:0], flash_mosi};
                    fbits++;
                    if (fbits == 32) begin
                        cmds_seen++;
                        check("command", fcmd, EXP_CMD);
                    end
                end else if (flash_mosi) mosi_bad++;
            end
            if (!flash_clk && prev_fclk && fbits == 32 && fbyte < 16) begin
                fcur = flash_data[fbyte];
                flash_miso = fcur[7 - fbit];
                fbit++;
                if (fbit == 8) begin fbit = 0; fbyte++; end
            end
            if (busy_ack && flash_clk != prev_fclk) stall_bad++;
        end
        prev_fclk = flash_clk;
    end

    // RAMIO responder: busy for 5 cycles after each accepted write.
    always begin
        @(negedge clk);
        if (ramio_enable) begin
            @(posedge clk); #1 busy_ack = 1'b1;
            repeat (5) @(posedge clk);
            #1 busy_ack = 1'b0;
        end
    end

    // Monitor: pops the expected write for every enable pulse.
    always @(negedge clk) begin
        if (rst_n && ramio_enable) begin
            check("pulse_width", {31'b0, prev_en}, 32'd0);
            check("enable_while_busy", {31'b0, ramio_busy}, 32'd0);
            check("read_type", {29'b0, ramio_read_type}, 32'd0);
            check("write_type", {30'b0, ramio_write_type}, 32'd3);
            if (exp_q.size() == 0) check("unexpected_write", ramio_address, 32'hxxxx_xxxx);
            else begin
                e = exp_q.pop_front();
                check("wr_addr", ramio_address, e.addr);
                check("wr_data", ramio_data_in, e.data);
            end
        end
        prev_en = ramio_enable;
    end

    task automatic cs_fall_check();
        int n = 0;
        while (flash_cs && n < 100) begin @(posedge clk); #1; n++; end
        check("cs_fall_cycles", n, 32'd10);
    endtask

    task automatic wait_q_size(input int k);
        for (int i = 0; i < 3000 && exp_q.size() != k; i++) @(negedge clk);
        check("queue_drain", exp_q.size(), k);
    endtask

    initial begin
        int hi = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", {31'b0, flash_cs}, 32'd1);
        check("rst_fclk", {31'b0, flash_clk}, 32'd0);
        check("rst_mosi", {31'b0, flash_mosi}, 32'd0);
        check("rst_en", {31'b0, ramio_enable}, 32'd0);
        check("rst_wt", {30'b0, ramio_write_type}, 32'd0);
        check("rst_rt", {29'b0, ramio_read_type}, 32'd0);
        check("rst_addr", ramio_address, RSTART);
        check("rst_data", ramio_data_in, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);

        // First run: one word, then reset asynchronously in the middle of the next byte.
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back('{RSTART, 32'h4433_2211});
        cs_fall_check();
        wait_q_size(0);
        repeat (20) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_cs", {31'b0, flash_cs}, 32'd1);
        check("async_en", {31'b0, ramio_enable}, 32'd0);
        check("async_fclk", {31'b0, flash_clk}, 32'd0);
        check("async_addr", ramio_address, RSTART);
        repeat (2) @(negedge clk);

        // Second run: full copy with wrap, busy held across the second Write.
        rst_n = 1'b1;
        exp_q.push_back('{RSTART, 32'h4433_2211});
        exp_q.push_back('{RSTART + 32'd4, 32'h8877_6655});
        exp_q.push_back('{32'h0000_0000, 32'hCCBB_AA99});
        cs_fall_check();
        wait_q_size(2);
        for (int i = 0; i < 100 && !flash_clk; i++) @(negedge clk);
        check("resume_after_busy", {31'b0, flash_clk}, 32'd1);
        busy_hold = 1'b1;
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            if (i >= 70 && flash_clk) hi++;
        end
        check("paused_sclk_highs", hi, 32'd0);
        check("paused_cs", {31'b0, flash_cs}, 32'd0);
        check("no_write_while_held", exp_q.size(), 32'd2);
        busy_hold = 1'b0;
        wait_q_size(1);
        wait_q_size(0);
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);
        check("done", {31'b0, done}, 32'd1);
        check("done_cs", {31'b0, flash_cs}, 32'd1);
        check("done_fclk", {31'b0, flash_clk}, 32'd0);
        check("done_addr", ramio_address, 32'd0);
        check("done_en", {31'b0, ramio_enable}, 32'd0);
        repeat (30) @(negedge clk);
        check("done_sticky", {31'b0, done}, 32'd1);
        check("no_extra_writes", exp_q.size(), 32'd0);
        check("commands_seen", cmds_seen, 32'd2);
        check("sclk_during_busy", stall_bad, 32'd0);
        check("mosi_after_cmd", mosi_bad, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flash_loader.md
Name: flash_loader

Overview:
- Boot-time stage between the SPI flash pins and the RAMIO interface.
- After reset, it waits a fixed number of cycles, then issues a standard SPI READ (0x03) to the flash.
- It streams FlashTransferBytes bytes, packs them into little-endian 32-bit words and writes them through the ramio_* master port starting at RAM address 0.
- It asserts done when the copy is finished; the core is held off RAMIO until then.

Parameters:
- StartupWaitCycles, 1_000_000: clk cycles to idle after reset before the first flash_cs assertion.
- FlashTransferBytes, 4096: bytes to copy; must be a nonzero multiple of 4.
- FlashStartAddress, 24'h000000: 24-bit flash byte address sent after the command.
- RamStartAddress, 32'h0000_0000: RAM byte address of the first word written.

Ports:
- clk  in  1  system clock (br_clk_out domain, 30 MHz)
- rst_n  in  1  asynchronous active-low reset
- flash_clk  out  1  SPI clock, clk/2
- flash_miso  in  1  SPI data from flash
- flash_mosi  out  1  SPI data to flash
- flash_cs  out  1  SPI chip select, active low
- ramio_enable  out  1  RAMIO request valid
- ramio_write_type  out  2  00 none, 01 byte, 10 half, 11 word; always 11 when writing
- ramio_read_type  out  3  always 0
- ramio_address  out  32  byte address of word write
- ramio_data_in  out  32  word to write
- ramio_busy  in  1  RAMIO cannot accept / operation in progress
- done  out  1  copy complete, sticky until reset

Behaviour:
- Reset values: flash_cs=1, flash_clk=0, flash_mosi=0, ramio_enable=0, ramio_write_type=0, ramio_read_type=0, ramio_address=RamStartAddress, ramio_data_in=0, done=0.
- States: Wait, Command, Receive, Write, WaitBusy, Done.
- Wait:
  - A down-counter is loaded with StartupWaitCycles.
  - At 0: flash_cs=0, and the 32-bit shift register is loaded with {8'h03, FlashStartAddress}. Go to Command.
- SPI framing:
  - SPI mode 0; flash_clk toggles every clk cycle while in Command/Receive.
  - flash_mosi is updated while flash_clk=0 (before the rising edge).
  - flash_miso is sampled on the cycle flash_clk goes 0->1.
  - Data is MSB first.
- Command:
  - Shifts 32 bits.
  - After the 32nd falling edge, go to Receive with bit counter=0.
  - flash_mosi is held 0 from then on.
- Receive:
  - Shifts 8 bits into a byte register.
  - On byte complete, the byte is placed at lane byte_index[1:0] of the word register (little-endian: first byte -> [7:0]).
  - When lane 3 is filled: flash_clk is held 0 (SPI paused; flash_cs stays 0), then go to Write.
- Write:
  - If ramio_busy=0: assert ramio_enable=1, write_type=11, address, data_in for exactly one cycle, then go to WaitBusy.
  - If ramio_busy=1: remain in Write with enable=0 until it clears.
- WaitBusy:
  - Waits until ramio_busy=0; the busy it samples is from the cycle after enable.
  - Then ramio_address += 4 (wraps modulo 2^32) and the byte count is incremented by 4.
  - If the byte count == FlashTransferBytes: flash_cs=1, flash_clk=0, go to Done.
  - Else return to Receive and resume clocking.
- Done:
  - done=1, all ramio outputs 0, flash_cs=1.
  - Absorbing until reset.
- Throughput: 16 clk cycles per byte plus RAMIO write latency per word. No bytes are lost across pauses because SPI is clock-stalled.
- Reset mid-operation: all state returns to reset values immediately, and flash_cs deasserts asynchronously. On release, the sequence restarts from Wait, including a new command.
- A byte counter width of $clog2(FlashTransferBytes+1) is sufficient.

Decomposition:
- Shared package (already holds RAMIO types) gains:
  - the write_type encodings (WriteNone/Byte/Half/Word);
  - the FLASH_CMD_READ=8'h03 constant;
  - the flash_loader_state_e enum.
- One sub-module is natural: spi_shifter. It owns flash_clk generation, 8/32-bit MSB-first shift, and a pause input. The FSM, word packing and RAMIO handshake live in flash_loader.

Test Plan:
- StartupWaitCycles=10, FlashTransferBytes=4 -> flash_cs falls on cycle 10 after reset release; mosi carries 0x03,0x00,0x00,0x00 over 32 flash_clk rising edges.
- Flash model returns 0x11,0x22,0x33,0x44 -> exactly one ramio_enable pulse with address 0x0, data_in 0x44332211, write_type 11; then done=1, flash_cs=1.
- FlashTransferBytes=12 with ramio_busy held high 5 cycles after each enable -> three writes at addresses 0x0, 0x4, 0x8. Clock is stalled during busy (no flash_clk edges), data is intact, and no enable occurs while busy.
- ramio_busy=1 when entering Write -> enable stays 0 until busy drops, then a single 1-cycle pulse.
- rst_n pulsed low mid-byte during Receive -> flash_cs=1 and ramio_enable=0 asynchronously. After release: full Wait, new 0x03 command, first write again at 0x0.
- RamStartAddress=32'hFFFF_FFFC, 8 bytes -> writes at 0xFFFFFFFC then 0x00000000, then done=1.
